// File: rtl/dvs_ravens_pkg.sv
// Shared DVS sensor / RAVENS interface constants and types, used by the AER
// receiver and the spike scheduler.
package dvs_ravens_pkg;

    localparam int DVS_WIDTH_PXLS    = 346;
    localparam int DVS_HEIGHT_PXLS   = 80;
    localparam int DVS_X_ADDR_BITS   = 9;
    localparam int DVS_Y_ADDR_BITS   = 7;
    localparam int TIMESTAMP_US_BITS = 32;

    localparam int SCHED_FIFO_DEPTH  = 16;
    localparam int TIMESTEP_SHIFT    = 10;
    localparam int NEURON_ID_BITS    = 16;

    typedef struct packed {
        logic [DVS_X_ADDR_BITS-1:0]   x;
        logic [DVS_Y_ADDR_BITS-1:0]   y;
        logic [TIMESTAMP_US_BITS-1:0] timestamp;
        logic                         polarity;
    } dvs_event_t;

    typedef enum logic [1:0] {
        IDLE,
        SPIKE,
        RUN
    } sched_state_e;

endpackage

// File: rtl/dvs_event_fifo.sv
// Synchronous event FIFO; a pop in the same cycle frees a slot so a push
// into a full FIFO is still accepted.
module dvs_event_fifo
    import dvs_ravens_pkg::*;
#(
    parameter int DEPTH = SCHED_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  dvs_event_t wr_data,
    input  logic       pop,
    output dvs_event_t rd_data,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    dvs_event_t  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/dvs_spike_scheduler.sv
// Buffers DVS events and sequences spikes plus "run N timesteps" commands
// onto the RAVENS input port so each spike lands in its own timestep.
module dvs_spike_scheduler #(
    parameter int FIFO_DEPTH     = dvs_ravens_pkg::SCHED_FIFO_DEPTH,
    parameter int X_SHIFT        = 0,
    parameter int Y_SHIFT        = 0,
    parameter int GRID_W         = (dvs_ravens_pkg::DVS_WIDTH_PXLS + 2**X_SHIFT - 1) >> X_SHIFT,
    parameter int TS_SHIFT       = dvs_ravens_pkg::TIMESTEP_SHIFT,
    parameter int NEURON_ID_BITS = dvs_ravens_pkg::NEURON_ID_BITS,
    parameter int RUN_BITS       = 8,
    parameter int DROP_BITS      = 16
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         enable,
    input  logic                                         ev_valid,
    input  logic [dvs_ravens_pkg::DVS_X_ADDR_BITS-1:0]   ev_x,
    input  logic [dvs_ravens_pkg::DVS_Y_ADDR_BITS-1:0]   ev_y,
    input  logic [dvs_ravens_pkg::TIMESTAMP_US_BITS-1:0] ev_timestamp,
    input  logic                                         ev_polarity,
    output logic                                         spike_valid,
    output logic [NEURON_ID_BITS-1:0]                    spike_id,
    input  logic                                         spike_ready,
    output logic                                         run_valid,
    output logic [RUN_BITS-1:0]                          run_steps,
    input  logic                                         run_ready,
    output logic                                         overflow,
    input  logic                                         ovf_clr,
    output logic [DROP_BITS-1:0]                         drop_count
);

    import dvs_ravens_pkg::*;

    localparam int STEP_BITS = TIMESTAMP_US_BITS - TS_SHIFT;
    localparam int MAX_ID    = 2 * (((DVS_HEIGHT_PXLS - 1) >> Y_SHIFT) * GRID_W
                                    + ((DVS_WIDTH_PXLS - 1) >> X_SHIFT)) + 1;
    localparam logic [STEP_BITS-1:0] RUN_MAX = STEP_BITS'((1 << RUN_BITS) - 1);

    if (NEURON_ID_BITS < 31 && MAX_ID >= (1 << NEURON_ID_BITS)) begin : g_id_range
        $error("dvs_spike_scheduler: largest neuron ID does not fit in NEURON_ID_BITS");
    end

    dvs_event_t           wr_ev;
    dvs_event_t           head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;
    logic                 drop;
    sched_state_e         state;
    logic                 synced;
    logic [STEP_BITS-1:0] cur_step;
    logic [STEP_BITS-1:0] head_step;
    logic [STEP_BITS-1:0] diff;
    logic [RUN_BITS-1:0]  run_clip;
    logic [31:0]          id_full;
    logic                 unused_bits;

    assign wr_ev = {ev_x, ev_y, ev_timestamp, ev_polarity};
    assign pop   = spike_valid && spike_ready;
    assign drop  = ev_valid && fifo_full && !pop;

    dvs_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (ev_valid),
        .wr_data (wr_ev),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // A gap with its MSB set means the event is late: spike it right away.
    assign head_step = head.timestamp[TIMESTAMP_US_BITS-1:TS_SHIFT];
    assign diff      = head_step - cur_step;
    assign run_clip  = (diff > RUN_MAX) ? RUN_BITS'(RUN_MAX) : diff[RUN_BITS-1:0];

    assign id_full = ((32'(head.y) >> Y_SHIFT) * 32'(GRID_W) + (32'(head.x) >> X_SHIFT)) * 32'd2
                     + 32'(head.polarity);
    assign unused_bits = ^{head.timestamp[TS_SHIFT-1:0], id_full};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            spike_valid <= 1'b0;
            spike_id    <= '0;
            run_valid   <= 1'b0;
            run_steps   <= '0;
            cur_step    <= '0;
            synced      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable && !fifo_empty) begin
                        if (!synced || diff == '0 || diff[STEP_BITS-1]) begin
                            // First event only anchors the step counter, no run.
                            if (!synced) begin
                                cur_step <= head_step;
                                synced   <= 1'b1;
                            end
                            spike_valid <= 1'b1;
                            spike_id    <= id_full[NEURON_ID_BITS-1:0];
                            state       <= SPIKE;
                        end else begin
                            run_valid <= 1'b1;
                            run_steps <= run_clip;
                            state     <= RUN;
                        end
                    end
                end
                SPIKE: begin
                    if (spike_ready) begin
                        spike_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                RUN: begin
                    if (run_ready) begin
                        run_valid <= 1'b0;
                        cur_step  <= cur_step + STEP_BITS'(run_steps);
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (ovf_clr) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != '1) drop_count <= drop_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_dvs_spike_scheduler.sv
// Bench for dvs_spike_scheduler: vector table, corner-case sequences and
// randomized batches checked against a timestep-level reference model.
module tb_dvs_spike_scheduler;
    import dvs_ravens_pkg::*;

    localparam int STEP_MASK = (1 << 22) - 1;
    localparam int LATE_BIT  = 1 << 21;
    localparam int RUN_TAG   = 65536;

    logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0, ev_valid = 1'b0, ev_polarity = 1'b0;
    logic        spike_ready = 1'b0, run_ready = 1'b0, ovf_clr = 1'b0;
    logic [8:0]  ev_x = '0;
    logic [6:0]  ev_y = '0;
    logic [31:0] ev_timestamp = '0;
    logic        spike_valid, run_valid, overflow;
    logic [15:0] spike_id;
    logic [3:0]  run_steps, drop_count;

    always #5 clk = ~clk;

    dvs_spike_scheduler #(
        .FIFO_DEPTH(4), .X_SHIFT(1), .Y_SHIFT(1), .TS_SHIFT(10),
        .NEURON_ID_BITS(16), .RUN_BITS(4), .DROP_BITS(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .ev_valid(ev_valid),
        .ev_x(ev_x), .ev_y(ev_y), .ev_timestamp(ev_timestamp), .ev_polarity(ev_polarity),
        .spike_valid(spike_valid), .spike_id(spike_id), .spike_ready(spike_ready),
        .run_valid(run_valid), .run_steps(run_steps), .run_ready(run_ready),
        .overflow(overflow), .ovf_clr(ovf_clr), .drop_count(drop_count)
    );

    typedef struct { int x; int y; int pol; int ts; int run; int id; } vec_t;
    vec_t vecs[8];

    int checks = 0, errors = 0;
    int exp_q[$], got_q[$];
    int both_err, stab_err, extra;
    int m_cur, m_synced;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        ev_valid = 0; spike_ready = 0; run_ready = 0; ovf_clr = 0; rst_n = 0;
        tick(); tick();
        rst_n = 1;
        tick();
    endtask

    task automatic push_ev(input int x, input int y, input int pol, input logic [31:0] ts);
        ev_x = 9'(x); ev_y = 7'(y); ev_polarity = 1'(pol); ev_timestamp = ts;
        ev_valid = 1;
        tick();
        ev_valid = 0;
    endtask

    // Reference: walk each event's target timestep from the current one in
    // chunks of at most 15, then emit its spike.
    task automatic model_ev(input int x, input int y, input int pol, input int step);
        int d, r;
        if (m_synced == 0) begin
            m_cur = step;
            m_synced = 1;
        end else begin
            d = (step - m_cur) & STEP_MASK;
            if (d >= LATE_BIT) d = 0;
            while (d > 0) begin
                r = (d > 15) ? 15 : d;
                exp_q.push_back(RUN_TAG + r);
                m_cur = (m_cur + r) & STEP_MASK;
                d -= r;
            end
        end
        exp_q.push_back(2 * ((y >> 1) * 173 + (x >> 1)) + pol);
    endtask

    task automatic drain(input bit rnd);
        int psv, prv, psr, prr, pid, prs, cyc;
        got_q.delete();
        both_err = 0; stab_err = 0; extra = 0; cyc = 0;
        while (got_q.size() < exp_q.size() && cyc < 600) begin
            spike_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            run_ready   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (spike_valid && run_valid) both_err++;
            if (spike_valid && spike_ready) got_q.push_back(int'(spike_id));
            if (run_valid && run_ready) got_q.push_back(RUN_TAG + int'(run_steps));
            psv = int'(spike_valid); prv = int'(run_valid);
            psr = int'(spike_ready); prr = int'(run_ready);
            pid = int'(spike_id);    prs = int'(run_steps);
            tick();
            cyc++;
            if (psv == 1 && psr == 0 && (!spike_valid || int'(spike_id) != pid)) stab_err++;
            if (prv == 1 && prr == 0 && (!run_valid || int'(run_steps) != prs)) stab_err++;
        end
        spike_ready = 0; run_ready = 0;
        repeat (4) begin
            tick();
            if (spike_valid || run_valid) extra++;
        end
    endtask

    task automatic compare(input string name);
        chk({name, " count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk({name, " item"}, got_q[i], exp_q[i]);
        chk({name, " exclusive"}, both_err, 0);
        chk({name, " stable"}, stab_err, 0);
        chk({name, " extra"}, extra, 0);
        exp_q.delete();
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        vecs[0] = '{10, 4, 1, 100, 0, 703};
        vecs[1] = '{0, 0, 0, 200, 0, 0};
        vecs[2] = '{345, 79, 1, 1023, 0, 13839};
        vecs[3] = '{1, 1, 0, 3100, 3, 0};
        vecs[4] = '{344, 2, 0, 3072, 0, 690};
        vecs[5] = '{7, 9, 1, 18432, 15, 1391};
        vecs[6] = '{100, 50, 0, 10240, 0, 8750};
        vecs[7] = '{2, 0, 1, 19456, 1, 3};

        // Reset state
        tick(); tick();
        chk("reset spike_valid", int'(spike_valid), 0);
        chk("reset run_valid", int'(run_valid), 0);
        chk("reset overflow", int'(overflow), 0);
        chk("reset drop_count", int'(drop_count), 0);
        enable = 1;
        rst_n = 1;
        cnt = 0;
        repeat (3) begin tick(); if (spike_valid || run_valid) cnt++; end
        chk("idle after reset", cnt, 0);

        // Vector table: mapping, latency, run gaps, late events
        do_reset();
        for (int i = 0; i < 8; i++) begin
            push_ev(vecs[i].x, vecs[i].y, vecs[i].pol, 32'(vecs[i].ts));
            chk("latency n+1 idle", int'(spike_valid | run_valid), 0);
            tick();
            if (vecs[i].run == 0) begin
                chk("latency n+2 spike_valid", int'(spike_valid), 1);
                chk("spike_id", int'(spike_id), vecs[i].id);
            end else begin
                chk("run_valid", int'(run_valid), 1);
                chk("run_steps", int'(run_steps), vecs[i].run);
            end
            if (vecs[i].run != 0) exp_q.push_back(RUN_TAG + vecs[i].run);
            exp_q.push_back(vecs[i].id);
            drain(0);
            compare("vec");
        end

        // Run-length saturation: gap of 40 steps with 4-bit run_steps
        do_reset();
        push_ev(0, 0, 0, 32'd0);
        push_ev(2, 0, 0, 32'd40960);
        exp_q = '{0, RUN_TAG + 15, RUN_TAG + 15, RUN_TAG + 10, 2};
        drain(0);
        compare("saturate");

        // Step counter wrap and late event
        do_reset();
        push_ev(4, 2, 1, 32'hFFFF_FC00);
        push_ev(6, 0, 0, 32'd100);
        push_ev(8, 0, 1, 32'hFFFF_EC00);
        exp_q = '{351, RUN_TAG + 1, 6, 9};
        drain(0);
        compare("wrap");

        // Enable gating and valid held while enable drops
        do_reset();
        enable = 0;
        push_ev(0, 0, 1, 32'd0);
        tick(); tick();
        chk("disabled no spike", int'(spike_valid), 0);
        enable = 1;
        tick();
        chk("enabled spike", int'(spike_valid), 1);
        enable = 0;
        tick();
        chk("valid held with enable low", int'(spike_valid), 1);
        enable = 1;
        exp_q = '{1};
        drain(0);
        compare("enable");

        // Overflow, clear priority, drop saturation, push+pop on full
        do_reset();
        for (int i = 0; i < 6; i++) begin
            push_ev(2 * i, 0, 0, 32'd500);
            if (i >= 1) chk("held spike_id", int'(spike_valid) * 65536 + int'(spike_id), 65536);
        end
        chk("overflow set", int'(overflow), 1);
        chk("drop_count 2", int'(drop_count), 2);
        ovf_clr = 1; tick(); ovf_clr = 0;
        chk("clr overflow", int'(overflow), 0);
        chk("clr drop_count", int'(drop_count), 0);
        ovf_clr = 1; ev_valid = 1; tick(); ovf_clr = 0;
        chk("clr wins overflow", int'(overflow), 0);
        chk("clr wins drop_count", int'(drop_count), 0);
        repeat (20) tick();
        ev_valid = 0;
        chk("drop_count saturates", int'(drop_count), 15);
        chk("overflow after drops", int'(overflow), 1);
        ovf_clr = 1; tick(); ovf_clr = 0;
        ev_x = 9'd20; ev_polarity = 0; ev_valid = 1; spike_ready = 1;
        chk("head before pop", int'(spike_id), 0);
        tick();
        ev_valid = 0; spike_ready = 0;
        chk("push+pop full no drop", int'(drop_count), 0);
        chk("push+pop full no overflow", int'(overflow), 0);
        exp_q = '{2, 4, 6, 20};
        drain(0);
        compare("overflow");

        // Asynchronous reset in the middle of a held handshake
        for (int i = 0; i < 6; i++) push_ev(2 * i, 0, 0, 32'd500);
        @(posedge clk); #3;
        rst_n = 0;
        #1;
        chk("async rst spike_valid", int'(spike_valid), 0);
        chk("async rst spike_id", int'(spike_id), 0);
        chk("async rst run_valid", int'(run_valid), 0);
        chk("async rst overflow", int'(overflow), 0);
        chk("async rst drop_count", int'(drop_count), 0);
        tick();
        rst_n = 1;
        cnt = 0;
        repeat (4) begin tick(); if (spike_valid || run_valid) cnt++; end
        chk("fifo empty after async rst", cnt, 0);

        // Randomized batches against the reference model
        do_reset();
        m_synced = 0; m_cur = 0;
        for (int b = 0; b < 30; b++) begin
            int n, x, y, pol, step, sel;
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) begin
                x = $urandom_range(0, 345);
                y = $urandom_range(0, 79);
                pol = $urandom_range(0, 1);
                sel = $urandom_range(0, 9);
                if (m_synced == 0)  step = $urandom_range(0, STEP_MASK);
                else if (sel < 6)   step = (m_cur + int'($urandom_range(0, 40))) & STEP_MASK;
                else if (sel < 8)   step = m_cur;
                else                step = (m_cur - int'($urandom_range(1, 100))) & STEP_MASK;
                model_ev(x, y, pol, step);
                push_ev(x, y, pol, (32'(step) << 10) | 32'($urandom_range(0, 1023)));
            end
            drain(1);
            compare("random");
        end
        chk("random no drops", int'(drop_count), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
